// File: rtl/led_pkg.sv
// Shared types and elaboration-time helpers for the LED pattern generator.
// Everything here is evaluated at elaboration; nothing in it becomes logic.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_t;

    // clk cycles per pattern tick
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // prescaler counter width; never below one bit
    function automatic int calc_div_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // channel-select width; a single channel still gets a one-bit select
    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Shared prescaler: counts 0..DIV-1 and flags the last count as the tick.
// The tick is a decode of a register, so it carries no path from any input.
module tick_gen
    import led_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = calc_div_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel OFF/ON/BLINK/BREATHE
// driven from a shared tick and a shared free-running PWM counter.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_HZ     = 40_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int CHANNELS   = 4,
    parameter int PERIOD_W   = 16,
    parameter int PWM_W      = 8,
    parameter int RST_PERIOD = 500
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [ch_width(CHANNELS)-1:0]  cfg_ch,
    input  logic [1:0]                     cfg_mode,
    input  logic [PERIOD_W-1:0]            cfg_period,
    output logic [CHANNELS-1:0]            led,
    output logic                           tick
);

    localparam int DIV  = calc_div(CLK_HZ, TICK_HZ);
    localparam int CH_W = ch_width(CHANNELS);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("led_pattern_gen: CLK_HZ/TICK_HZ must be at least 2");
        end
        if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_ch
            $error("led_pattern_gen: CHANNELS must be in 1..16");
        end
    endgenerate

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    logic [PWM_W-1:0]    pwm_cnt;
    logic [CHANNELS-1:0] led_nxt;

    always_ff @(posedge clk) begin
        if (rst)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_mode_t           mode_q;
        logic [PERIOD_W-1:0] period_q;
        logic [PERIOD_W-1:0] cnt_q;
        logic [PERIOD_W-1:0] p_eff;
        logic                blink_q;
        logic                dir_up_q;
        logic [PWM_W-1:0]    duty_q;
        logic                wr;
        logic                wrap;
        logic                running;

        // Out-of-range selects never match any generated index, so they fall away.
        assign wr      = cfg_we && (cfg_ch == CH_W'(i));
        assign p_eff   = (period_q == '0) ? PERIOD_W'(1) : period_q;
        assign wrap    = (cnt_q == p_eff - PERIOD_W'(1));
        assign running = (mode_q == MODE_BLINK) || (mode_q == MODE_BREATHE);

        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q   <= MODE_OFF;
                period_q <= PERIOD_W'(RST_PERIOD);
                cnt_q    <= '0;
                blink_q  <= 1'b0;
                duty_q   <= '0;
                dir_up_q <= 1'b1;
            end else if (wr) begin
                // a write swallows a coincident tick for this channel
                mode_q   <= led_mode_t'(cfg_mode);
                period_q <= cfg_period;
                cnt_q    <= '0;
                blink_q  <= 1'b0;
                duty_q   <= '0;
                dir_up_q <= 1'b1;
            end else if (tick && running) begin
                if (!wrap) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    cnt_q <= '0;
                    if (mode_q == MODE_BLINK) begin
                        blink_q <= ~blink_q;
                    end else if (dir_up_q) begin
                        // turning around holds the endpoint for one step
                        if (duty_q == '1)
                            dir_up_q <= 1'b0;
                        else
                            duty_q <= duty_q + 1'b1;
                    end else begin
                        if (duty_q == '0)
                            dir_up_q <= 1'b1;
                        else
                            duty_q <= duty_q - 1'b1;
                    end
                end
            end
        end

        assign led_nxt[i] = (mode_q == MODE_ON)
                          | ((mode_q == MODE_BLINK)   & blink_q)
                          | ((mode_q == MODE_BREATHE) & (pwm_cnt < duty_q));
    end

    always_ff @(posedge clk) begin
        if (rst)
            led <= '0;
        else
            led <= led_nxt;
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus random writes, checked
// every cycle against a tick-count model; a 3-channel copy covers bad selects.
module tb_led_pattern_gen;

    localparam int CH   = 4;
    localparam int PW   = 4;
    localparam int RSTP = 500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_period = '0;
    logic [3:0]  led;
    logic        tick;
    logic [2:0]  led3;
    logic        tick3;

    led_pattern_gen #(
        .CLK_HZ(100), .TICK_HZ(10), .CHANNELS(4),
        .PERIOD_W(16), .PWM_W(PW), .RST_PERIOD(RSTP)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .led(led), .tick(tick)
    );

    // channel 3 does not exist here, so writes to it must vanish
    led_pattern_gen #(
        .CLK_HZ(100), .TICK_HZ(10), .CHANNELS(3),
        .PERIOD_W(16), .PWM_W(PW), .RST_PERIOD(RSTP)
    ) dut3 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .led(led3), .tick(tick3)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int k;            // clk edges since reset release
    int mmode [CH];
    int mp    [CH];   // effective period
    int mt    [CH];   // ticks consumed since last write

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s: got %0h want %0h (k=%0d)", tag, got, want, k);
        end
    endtask

    function automatic int tri_duty(input int s);
        int m = 1 << PW;
        int r = s % (2 * m);
        return (r < m) ? r : (2 * m - 1 - r);
    endfunction

    function automatic logic model_led(input int i);
        int s = mt[i] / mp[i];
        case (mmode[i])
            1:       return 1'b1;
            2:       return (s % 2) == 1;
            3:       return (k % 16) < tri_duty(s);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            mmode[i] = 0;
            mp[i]    = RSTP;
            mt[i]    = 0;
        end
        k = 0;
    endtask

    task automatic cyc(input logic we, input int ch, input int mode, input int per);
        logic [3:0] el;
        logic       et;
        logic       tick_now;
        cfg_we     = we;
        cfg_ch     = ch[1:0];
        cfg_mode   = mode[1:0];
        cfg_period = per[15:0];
        @(posedge clk);
        for (int i = 0; i < CH; i++) el[i] = model_led(i);
        tick_now = (k % 10) == 9;
        for (int i = 0; i < CH; i++) begin
            if (we && ch == i) begin
                mmode[i] = mode;
                mp[i]    = (per == 0) ? 1 : per;
                mt[i]    = 0;
            end else if (tick_now && mmode[i] >= 2) begin
                mt[i]++;
            end
        end
        k++;
        et = (k % 10) == 9;
        #1;
        chk("led", 32'(led), 32'(el));
        chk("tick", 32'(tick), 32'(et));
        chk("led3", 32'(led3), 32'(el[2:0]));
        chk("tick3", 32'(tick3), 32'(et));
        cfg_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rst    = 1'b1;
        cfg_we = 1'b0;
        repeat (n) begin
            @(posedge clk);
            model_reset();
            #1;
            chk("rst_led", 32'(led), 32'd0);
            chk("rst_tick", 32'(tick), 32'd0);
            chk("rst_led3", 32'(led3), 32'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset(3);
        idle(100);

        cyc(1'b1, 1, 1, 0);       // ch1 ON
        idle(5);
        cyc(1'b1, 0, 2, 3);       // ch0 BLINK P=3
        idle(90);
        cyc(1'b1, 2, 3, 1);       // ch2 BREATHE P=1, two full ramps
        idle(700);
        cyc(1'b1, 3, 2, 0);       // ch3 BLINK P=0 -> every tick
        idle(45);
        cyc(1'b1, 3, 3, 2);       // ch3 write: dut3 must ignore it
        idle(30);

        cyc(1'b1, 2, 3, 1);       // reset mid-breathe
        idle(150);
        do_reset(2);
        idle(50);

        // write landing on the tick cycle restarts the count
        for (int n = 0; n < 10 && (k % 10) != 9; n++) idle(1);
        cyc(1'b1, 0, 2, 2);
        idle(60);

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 19) == 0)
                cyc(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 5)));
            else if ($urandom_range(0, 999) == 0)
                do_reset(1);
            else
                idle(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
